// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit (master) and the memory model (slave).
// Handshake: mem_req rises with mem_addr and both hold steady until a cycle where mem_ack=1;
// mem_rdata is valid only in that mem_ack cycle, and the request drops on the following edge.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ack;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC/IR holder with a req/ack instruction fetch toward memory for a multicycle CPU.
// Optional fetch timeout fault is built when FETCH_FAULT_EN is defined.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 IRWrite,
  input  logic                 PCWrite,
  input  logic                 PCSource,
  input  logic [ADDR_W-1:0]    alu_result,
  instruction_fetch_unit_if.master mem,
  output logic [ADDR_W-1:0]    pc,
  output logic [INSTR_W-1:0]   instr,
  output logic [3:0]           op,
  output logic                 fetch_busy,
  output logic                 fetch_done,
  output logic                 fetch_fault,
  output logic [1:0]           fetch_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_DONE = 2'd2} state_t;

  state_t               r_state, w_next_state;
  logic [ADDR_W-1:0]    r_pc, w_next_pc;
  logic [INSTR_W-1:0]   r_ir, w_next_ir;
  logic                 r_mem_req, w_next_mem_req;
  logic [ADDR_W-1:0]    r_mem_addr, w_next_mem_addr;
  logic                 r_busy, w_next_busy;
  logic                 r_done, w_next_done;

`ifdef FETCH_FAULT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_timer, w_next_timer;
  logic          r_fault, w_next_fault;
`endif

  always_comb begin
    w_next_state    = r_state;
    w_next_pc       = r_pc;
    w_next_ir       = r_ir;
    w_next_mem_req  = r_mem_req;
    w_next_mem_addr = r_mem_addr;
`ifdef FETCH_FAULT_EN
    w_next_timer    = r_timer;
    w_next_fault    = r_fault;
`endif
    if (PCWrite)
      w_next_pc = PCSource ? alu_result : r_pc + ADDR_W'(2);
    case (r_state)
      S_IDLE: begin
        // Fetch address is the PC before any same-edge PCWrite.
        if (IRWrite) begin
          w_next_state    = S_FETCH;
          w_next_mem_addr = r_pc;
          w_next_mem_req  = 1'b1;
`ifdef FETCH_FAULT_EN
          w_next_timer    = TW'(1);
`endif
        end
      end
      S_FETCH: begin
        if (mem.mem_ack) begin
          w_next_ir      = mem.mem_rdata;
          w_next_mem_req = 1'b0;
          w_next_state   = S_DONE;
`ifdef FETCH_FAULT_EN
          w_next_timer   = '0;
        end else if (r_timer == TW'(TIMEOUT)) begin
          w_next_mem_req = 1'b0;
          w_next_fault   = 1'b1;
          w_next_timer   = '0;
          w_next_state   = S_IDLE;
        end else begin
          w_next_timer   = r_timer + TW'(1);
`endif
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    w_next_busy = (w_next_state != S_IDLE);
    w_next_done = (w_next_state == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef FETCH_FAULT_EN
      r_timer    <= '0;
      r_fault    <= 1'b0;
`endif
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_ir       <= w_next_ir;
      r_mem_req  <= w_next_mem_req;
      r_mem_addr <= w_next_mem_addr;
      r_busy     <= w_next_busy;
      r_done     <= w_next_done;
`ifdef FETCH_FAULT_EN
      r_timer    <= w_next_timer;
      r_fault    <= w_next_fault;
`endif
    end
  end

`ifdef FETCH_FAULT_EN
  assign fetch_fault = r_fault;
`else
  assign fetch_fault = 1'b0;
`endif

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_mem_addr;
  assign pc           = r_pc;
  assign instr        = r_ir;
  assign op           = r_ir[INSTR_W-1 -: 4];
  assign fetch_busy   = r_busy;
  assign fetch_done   = r_done;
  assign fetch_state  = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + randomized-latency bench for instruction_fetch_unit; instruction words are
// scoreboarded through exp_q and compared when fetch_done pulses.
module tb_instruction_fetch_unit;
  localparam int W = 16;

  logic         CLK;
  logic         Reset;
  logic         IRWrite, PCWrite, PCSource;
  logic [W-1:0] alu_result;
  logic [W-1:0] pc, instr;
  logic [3:0]   op;
  logic         fetch_busy, fetch_done, fetch_fault;
  logic [1:0]   fetch_state;

  instruction_fetch_unit_if #(.ADDR_W(W), .INSTR_W(W)) mem_if ();

  instruction_fetch_unit #(.ADDR_W(W), .INSTR_W(W), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource),
    .alu_result(alu_result), .mem(mem_if), .pc(pc), .instr(instr), .op(op),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_fault(fetch_fault),
    .fetch_state(fetch_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  always @(negedge CLK) if (fetch_done === 1'b1) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change at negedge, outputs sampled at negedge
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic load_pc(input logic [W-1:0] v);
    PCWrite = 1'b1; PCSource = 1'b1; alu_result = v;
    tick();
    PCWrite = 1'b0; PCSource = 1'b0; alu_result = W'($urandom);
  endtask

  task automatic start_fetch();
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
  endtask

  task automatic ack_word(input logic [W-1:0] w);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = w;
    exp_q.push_back(w);
    tick();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = W'($urandom);
  endtask

  // scoreboard compare at the fetch_done cycle
  task automatic sb_check(input string tag);
    logic [W-1:0] e;
    check({tag, "_done"}, {31'd0, fetch_done}, 32'd1);
    check({tag, "_sb_pending"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_instr"}, {16'd0, instr}, {16'd0, e});
      check({tag, "_op"}, {28'd0, op}, {28'd0, e[15:12]});
    end
  endtask

  initial begin
    int d0;
    logic [W-1:0] w;
    Reset = 1'b1; IRWrite = 1'b0; PCWrite = 1'b0; PCSource = 1'b0; alu_result = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    tick(); tick();
    check("rst_pc", {16'd0, pc}, 32'h0000);
    check("rst_instr", {16'd0, instr}, 32'h0000);
    check("rst_req", {31'd0, mem_if.mem_req}, 32'd0);
    check("rst_addr", {16'd0, mem_if.mem_addr}, 32'd0);
    check("rst_done", {31'd0, fetch_done}, 32'd0);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_state", {30'd0, fetch_state}, 32'd0);
    Reset = 1'b0;
    tick();

    // basic fetch, ack on first FETCH cycle
    start_fetch();
    check("t1_req", {31'd0, mem_if.mem_req}, 32'd1);
    check("t1_addr", {16'd0, mem_if.mem_addr}, 32'h0000);
    check("t1_busy", {31'd0, fetch_busy}, 32'd1);
    check("t1_nodone", {31'd0, fetch_done}, 32'd0);
    ack_word(16'h3125);
    sb_check("t1");
    check("t1_op_const", {28'd0, op}, 32'h3);
    check("t1_req_drop", {31'd0, mem_if.mem_req}, 32'd0);
    tick();
    check("t1_done_pulse", {31'd0, fetch_done}, 32'd0);
    check("t1_idle_busy", {31'd0, fetch_busy}, 32'd0);

    // ack delayed 5 cycles
    load_pc(16'h0100);
    check("t2_pc", {16'd0, pc}, 32'h0100);
    d0 = done_cnt;
    start_fetch();
    for (int i = 0; i < 5; i++) begin
      mem_if.mem_rdata = W'($urandom);
      check("t2_req_hold", {31'd0, mem_if.mem_req}, 32'd1);
      check("t2_addr_hold", {16'd0, mem_if.mem_addr}, 32'h0100);
      tick();
    end
    ack_word(16'hA5C3);
    sb_check("t2");
    tick(); tick();
    check("t2_single_done", done_cnt - d0, 32'd1);

    // PC update and wrap
    load_pc(16'hFFFE);
    PCWrite = 1'b1; PCSource = 1'b0;
    tick();
    check("t3_wrap", {16'd0, pc}, 32'h0000);
    PCSource = 1'b1; alu_result = 16'h0040;
    tick();
    PCWrite = 1'b0; PCSource = 1'b0;
    check("t3_alu", {16'd0, pc}, 32'h0040);

    // IRWrite + PCWrite same edge; IRWrite during FETCH ignored
    load_pc(16'h0010);
    d0 = done_cnt;
    IRWrite = 1'b1; PCWrite = 1'b1; PCSource = 1'b0;
    tick();
    check("t4_addr", {16'd0, mem_if.mem_addr}, 32'h0010);
    check("t4_pc", {16'd0, pc}, 32'h0012);
    check("t4_req", {31'd0, mem_if.mem_req}, 32'd1);
    tick();
    IRWrite = 1'b0; PCWrite = 1'b0;
    check("t4_addr_after_pcw", {16'd0, mem_if.mem_addr}, 32'h0010);
    check("t4_pc2", {16'd0, pc}, 32'h0014);
    ack_word(16'h7E01);
    sb_check("t4");
    tick();
    check("t4_no_queue_req", {31'd0, mem_if.mem_req}, 32'd0);
    tick();
    check("t4_no_queue_busy", {31'd0, fetch_busy}, 32'd0);
    check("t4_one_done", done_cnt - d0, 32'd1);

    // Reset mid-FETCH with ack on the Reset edge
    d0 = done_cnt;
    start_fetch();
    tick();
    Reset = 1'b1; mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hBEEF;
    tick();
    Reset = 1'b0; mem_if.mem_ack = 1'b0;
    check("t5_instr", {16'd0, instr}, 32'h0000);
    check("t5_state", {30'd0, fetch_state}, 32'd0);
    check("t5_req", {31'd0, mem_if.mem_req}, 32'd0);
    check("t5_pc", {16'd0, pc}, 32'h0000);
    tick();
    check("t5_no_done", done_cnt - d0, 32'd0);
    check("t5_instr_hold", {16'd0, instr}, 32'h0000);

    // random latency fetches at random PCs
    for (int k = 0; k < 8; k++) begin
      int lat;
      logic [W-1:0] a;
      a = W'($urandom_range(0, 16'h7FFF) * 2);
      load_pc(a);
      lat = $urandom_range(0, 3);
      start_fetch();
      for (int i = 0; i < lat; i++) begin
        check("rnd_req", {31'd0, mem_if.mem_req}, 32'd1);
        tick();
      end
      check("rnd_addr", {16'd0, mem_if.mem_addr}, {16'd0, a});
      w = W'($urandom);
      ack_word(w);
      sb_check("rnd");
      tick();
    end

`ifdef FETCH_FAULT_EN
    // no ack: fault after 15 FETCH cycles
    d0 = done_cnt;
    start_fetch();
    for (int i = 1; i <= 15; i++) begin
      check("f_req_hold", {31'd0, mem_if.mem_req}, 32'd1);
      check("f_no_fault_yet", {31'd0, fetch_fault}, 32'd0);
      tick();
    end
    check("f_fault", {31'd0, fetch_fault}, 32'd1);
    check("f_req_drop", {31'd0, mem_if.mem_req}, 32'd0);
    check("f_idle", {30'd0, fetch_state}, 32'd0);
    check("f_no_done", done_cnt - d0, 32'd0);
    tick();
    check("f_sticky", {31'd0, fetch_fault}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("f_clear", {31'd0, fetch_fault}, 32'd0);
    // ack on cycle 15 wins
    start_fetch();
    for (int i = 1; i <= 14; i++) tick();
    ack_word(16'h9ABC);
    sb_check("f_ack15");
    check("f_ack15_nofault", {31'd0, fetch_fault}, 32'd0);
`else
    check("nofault_tied", {31'd0, fetch_fault}, 32'd0);
`endif

    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
